axis_event_serializer: RTL

- Sits directly downstream of the detector reader stage.
- Captures each 128-bit coincidence event {timestamp[63:0], hit mask[63:0]}. The source has no backpressure, so events land in a small internal FIFO.
- Each buffered event is emitted as four 32-bit AXI4-Stream words with full tready/tvalid handshake and tlast on the final word, ready for the DMA writer.
- Events arriving while the FIFO is full are dropped and counted.

---
 rtl/axis_event_pkg.sv | 37 +++
 rtl/axis_event_fifo.sv | 64 ++++++
 rtl/axis_event_serializer.sv | 106 ++++++++++
 3 files changed

// File: rtl/axis_event_pkg.sv
// Shared widths, field offsets, FSM encoding and the word-select helper for the event serializer.
package axis_event_pkg;

    localparam int unsigned EVENT_WIDTH     = 128;
    localparam int unsigned WORD_WIDTH      = 32;
    localparam int unsigned WORDS_PER_EVENT = 4;
    localparam int unsigned IDX_WIDTH       = 2;
    localparam int unsigned HIT_LSB         = 0;
    localparam int unsigned TIME_LSB        = 64;

    // Coincidence event as it arrives on s_axis_tdata
    typedef struct packed {
        logic [63:0] timestamp;
        logic [63:0] hit_mask;
    } event_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Word order on the stream: hit low, hit high, time low, time high
    function automatic logic [WORD_WIDTH-1:0] event_word(
        input logic [EVENT_WIDTH-1:0] ev,
        input logic [IDX_WIDTH-1:0]   idx
    );
        logic [WORD_WIDTH-1:0] w;
        case (idx)
            2'd0:    w = ev[HIT_LSB +: WORD_WIDTH];
            2'd1:    w = ev[HIT_LSB + WORD_WIDTH +: WORD_WIDTH];
            2'd2:    w = ev[TIME_LSB +: WORD_WIDTH];
            default: w = ev[TIME_LSB + WORD_WIDTH +: WORD_WIDTH];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/axis_event_fifo.sv
// Register-array event FIFO with show-ahead read data; full/empty derive from the registered count.
module axis_event_fifo #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data_c,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full_c,
    output logic                  empty_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Status from the registered count; a same-cycle pop never frees room for a push
    assign full_c    = (count == (ADDR_WIDTH + 1)'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_push   = push && !full_c;
    assign do_pop    = pop && !empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Storage array write port
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_event_serializer.sv
// Buffers 128-bit detector events and emits each as four 32-bit AXI4-Stream words with tlast on the fourth.
module axis_event_serializer
    import axis_event_pkg::*;
#(
    parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [EVENT_WIDTH-1:0]     s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic [WORD_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [FIFO_ADDR_WIDTH:0]   sts_level,
    output logic [31:0]                sts_dropped
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORDS_PER_EVENT - 1);

    ser_state_e             state;
    logic [EVENT_WIDTH-1:0] hold;
    logic [IDX_WIDTH-1:0]   idx;

    logic [EVENT_WIDTH-1:0] fifo_rd_data_c;
    logic [FIFO_ADDR_WIDTH:0] fifo_count;
    logic                   fifo_full_c;
    logic                   fifo_empty_c;
    logic                   fifo_pop_c;
    logic                   xfer_c;

    assign xfer_c     = m_axis_tvalid && m_axis_tready;
    assign fifo_pop_c = !fifo_empty_c &&
                        ((state == IDLE) || ((state == SEND) && xfer_c && (idx == LAST_IDX)));
    assign sts_level  = fifo_count;

    axis_event_fifo #(
        .ADDR_WIDTH (FIFO_ADDR_WIDTH),
        .DATA_WIDTH (EVENT_WIDTH)
    ) u_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (s_axis_tvalid),
        .wr_data   (s_axis_tdata),
        .pop       (fifo_pop_c),
        .rd_data_c (fifo_rd_data_c),
        .count     (fifo_count),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    // Saturating count of events that arrived with the FIFO full
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sts_dropped <= '0;
        end else if (s_axis_tvalid && fifo_full_c && (sts_dropped != '1)) begin
            sts_dropped <= sts_dropped + 32'd1;
        end
    end

    // Serializer FSM: registered word mux, tlast and tvalid advance only on a handshake
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            hold          <= '0;
            idx           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty_c) begin
                        hold          <= fifo_rd_data_c;
                        idx           <= '0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tdata  <= event_word(fifo_rd_data_c, '0);
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (xfer_c) begin
                        if (idx != LAST_IDX) begin
                            idx          <= idx + IDX_WIDTH'(1);
                            m_axis_tdata <= event_word(hold, idx + IDX_WIDTH'(1));
                            m_axis_tlast <= (idx == LAST_IDX - IDX_WIDTH'(1));
                        end else if (!fifo_empty_c) begin
                            hold         <= fifo_rd_data_c;
                            idx          <= '0;
                            m_axis_tlast <= 1'b0;
                            m_axis_tdata <= event_word(fifo_rd_data_c, '0);
                        end else begin
                            idx           <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
